// File: rtl/bullet_launcher.sv
// Fire-button launcher: allocates bullet slots on fire and frees them on retire.
// Latency: 2-flop sync + edge/FIRE decision, then slot_spawn registered one pixpulse later.
// Backpressure: a fire with no free slot (or during cooldown) is dropped, never queued.
module bullet_launcher #(
    parameter int MAX_BULLETS     = 3,
    parameter int COOLDOWN_FRAMES = 8,
    parameter int SPAWN_YOFF      = 12,
    parameter int AUTO_FIRE       = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     pixpulse,
    input  logic                     move,
    input  logic                     fire_btn,
    input  logic [9:0]               ship_xloc,
    input  logic [9:0]               ship_yloc,
    input  logic [MAX_BULLETS-1:0]   slot_retire,
    output logic [MAX_BULLETS-1:0]   slot_spawn,
    output logic [9:0]               spawn_xloc,
    output logic [9:0]               spawn_yloc,
    output logic [2*MAX_BULLETS-1:0] slot_bullet_count,
    output logic [MAX_BULLETS-1:0]   active_mask,
    output logic [1:0]               active_count,
    output logic                     retire_err
);
    typedef enum logic [1:0] {ST_READY, ST_FIRE, ST_COOL, ST_HOLD} state_t;

    localparam logic [9:0] YOFF      = 10'(SPAWN_YOFF);
    localparam logic [7:0] COOL_INIT = 8'(COOLDOWN_FRAMES);
    localparam logic       AUTO      = (AUTO_FIRE != 0);

    state_t                   state_q, state_d;
    logic                     btn_m_q, btn_s_q, btn_d_q, btn_d_d;
    logic [7:0]               cnt_q, cnt_d;
    logic [MAX_BULLETS-1:0]   mask_q, mask_d;
    logic [MAX_BULLETS-1:0]   spawn_q, spawn_d;
    logic [9:0]               xloc_q, xloc_d, yloc_q, yloc_d;
    logic [2*MAX_BULLETS-1:0] bcnt_q, bcnt_d;
    logic [1:0]               acnt_q, acnt_d;
    logic                     err_q, err_d;
    logic [MAX_BULLETS-1:0]   free, pick;
    logic                     fire_req;

    // Free slots are taken from the registered mask, i.e. before any same-cycle retire.
    always_comb begin
        free     = ~mask_q;
        fire_req = AUTO ? btn_s_q : (btn_s_q & ~btn_d_q);
        pick     = '0;
        for (int i = MAX_BULLETS - 1; i >= 0; i--) begin
            if (free[i]) begin
                pick    = '0;
                pick[i] = 1'b1;
            end
        end
    end

    // State register plus all datapath flops; the button synchroniser runs on every clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_READY;
            btn_m_q <= 1'b0;
            btn_s_q <= 1'b0;
            btn_d_q <= 1'b0;
            cnt_q   <= '0;
            mask_q  <= '0;
            spawn_q <= '0;
            xloc_q  <= '0;
            yloc_q  <= '0;
            bcnt_q  <= '1;
            acnt_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            btn_m_q <= fire_btn;
            btn_s_q <= btn_m_q;
            btn_d_q <= btn_d_d;
            cnt_q   <= cnt_d;
            mask_q  <= mask_d;
            spawn_q <= spawn_d;
            xloc_q  <= xloc_d;
            yloc_q  <= yloc_d;
            bcnt_q  <= bcnt_d;
            acnt_q  <= acnt_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic, advanced only on pixel-enable cycles.
    always_comb begin
        state_d = state_q;
        if (pixpulse) begin
            case (state_q)
                ST_READY: if (fire_req && |free) state_d = ST_FIRE;
                ST_FIRE:  state_d = ST_COOL;
                ST_COOL:  if (move && cnt_q == 8'd1)
                              state_d = (AUTO || !btn_s_q) ? ST_READY : ST_HOLD;
                ST_HOLD:  if (!btn_s_q) state_d = ST_READY;
                default:  state_d = ST_READY;
            endcase
        end
    end

    // Datapath: spawn/retire bookkeeping, cooldown count and derived per-slot fields.
    always_comb begin
        btn_d_d = btn_d_q;
        cnt_d   = cnt_q;
        mask_d  = mask_q;
        spawn_d = spawn_q;
        xloc_d  = xloc_q;
        yloc_d  = yloc_q;
        err_d   = err_q;
        if (pixpulse) begin
            btn_d_d = btn_s_q;
            spawn_d = '0;
            if (|(slot_retire & ~mask_q)) err_d = 1'b1;
            mask_d = mask_q & ~slot_retire;
            if (state_q == ST_FIRE) begin
                spawn_d = pick;
                mask_d  = mask_d | pick;
                xloc_d  = ship_xloc;
                yloc_d  = (ship_yloc < YOFF) ? 10'd0 : ship_yloc - YOFF;
                cnt_d   = COOL_INIT;
            end else if (state_q == ST_COOL && move) begin
                cnt_d = cnt_q - 8'd1;
            end
        end
        acnt_d = '0;
        for (int i = 0; i < MAX_BULLETS; i++) begin
            acnt_d          = acnt_d + 2'(mask_d[i]);
            bcnt_d[2*i +: 2] = mask_d[i] ? 2'b00 : 2'b11;
        end
    end

    assign slot_spawn        = spawn_q;
    assign spawn_xloc        = xloc_q;
    assign spawn_yloc        = yloc_q;
    assign slot_bullet_count = bcnt_q;
    assign active_mask       = mask_q;
    assign active_count      = acnt_q;
    assign retire_err        = err_q;
endmodule
